bcd_entry: RTL and testbench

BCD_ENTRY -- requirements
Module: bcd_entry

---
 rtl/bcd_entry_if.sv | 26 ++
 rtl/bcd_entry.sv | 152 +++++++++++++++
 tb/tb_bcd_entry.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_entry_if.sv
// Keypad-entry bus for bcd_entry: key strobes and limit in, accepted value,
// pulses and pending-entry display out.
interface bcd_entry_if;
  logic [3:0] dig;
  logic       dig_vld;
  logic       ent;
  logic       clr;
  logic [4:0] maxv;
  logic [4:0] val;
  logic       val_vld;
  logic       err;
  logic       tout;
  logic [1:0] ndig;
  logic [3:0] disp_bcd1;
  logic [3:0] disp_bcd0;

  modport master (
    output dig, dig_vld, ent, clr, maxv,
    input  val, val_vld, err, tout, ndig, disp_bcd1, disp_bcd0
  );

  modport slave (
    input  dig, dig_vld, ent, clr, maxv,
    output val, val_vld, err, tout, ndig, disp_bcd1, disp_bcd0
  );
endinterface

// File: rtl/bcd_entry.sv
// Two-digit BCD keypad entry to 5-bit binary with range/limit check.
// Optional inactivity timeout enabled by defining ENTRY_TIMEOUT_EN.
module bcd_entry #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input logic       clk,
  input logic       rst_n,
  bcd_entry_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ONE, TWO, CHECK} state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d, units_q, units_d;
  logic [4:0] val_q, val_d;
  logic       val_vld_q, val_vld_d;
  logic       err_q, err_d;
  logic [1:0] ndig_q, ndig_d;
  logic [3:0] disp1_q, disp1_d, disp0_q, disp0_d;
  logic [6:0] bin;
  logic       dig_ok;

  if (TIMEOUT_CYC == 32'd0) begin : g_bad_cfg
    $error("bcd_entry: TIMEOUT_CYC must be non-zero");
  end

  assign dig_ok = bus.dig_vld && (bus.dig <= 4'd9);
  assign bin    = ({3'b000, tens_q} * 7'd10) + {3'b000, units_q};

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        tout_q, tout_d;
  logic        expire;
  assign expire = (timer_q == (TIMEOUT_CYC - 32'd1));
`endif

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    val_d     = val_q;
    val_vld_d = 1'b0;
    err_d     = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    timer_d   = timer_q;
    tout_d    = 1'b0;
`endif
    if (state_q == CHECK) begin
      state_d = IDLE;
      tens_d  = '0;
      units_d = '0;
      if (!bus.clr) begin
        if ((bin <= 7'd31) && (bin <= {2'b00, bus.maxv})) begin
          val_d     = bin[4:0];
          val_vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.clr) begin
      state_d = IDLE;
      tens_d  = '0;
      units_d = '0;
    end else if (bus.ent) begin
      // ENT in IDLE is swallowed, but still masks a digit strobe in that cycle
      if (state_q != IDLE) state_d = CHECK;
    end else if (dig_ok && (state_q != TWO)) begin
      units_d = bus.dig;
      tens_d  = (state_q == IDLE) ? 4'd0 : units_q;
      state_d = (state_q == IDLE) ? ONE : TWO;
`ifdef ENTRY_TIMEOUT_EN
      timer_d = '0;
`endif
    end else if (state_q != IDLE) begin
`ifdef ENTRY_TIMEOUT_EN
      if (expire) begin
        state_d = IDLE;
        tens_d  = '0;
        units_d = '0;
        tout_d  = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
`endif
    end

    // Display/NDIG are registered from the next state so they track it exactly
    ndig_d  = 2'd0;
    disp1_d = 4'd0;
    disp0_d = 4'd0;
    case (state_d)
      ONE: begin
        ndig_d  = 2'd1;
        disp0_d = units_d;
      end
      TWO: begin
        ndig_d  = 2'd2;
        disp1_d = tens_d;
        disp0_d = units_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tens_q    <= '0;
      units_q   <= '0;
      val_q     <= '0;
      val_vld_q <= 1'b0;
      err_q     <= 1'b0;
      ndig_q    <= '0;
      disp1_q   <= '0;
      disp0_q   <= '0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      val_q     <= val_d;
      val_vld_q <= val_vld_d;
      err_q     <= err_d;
      ndig_q    <= ndig_d;
      disp1_q   <= disp1_d;
      disp0_q   <= disp0_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.tout = tout_q;
`else
  assign bus.tout = 1'b0;
`endif

  assign bus.val       = val_q;
  assign bus.val_vld   = val_vld_q;
  assign bus.err       = err_q;
  assign bus.ndig      = ndig_q;
  assign bus.disp_bcd1 = disp1_q;
  assign bus.disp_bcd0 = disp0_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Self-checking bench for bcd_entry: directed scenarios plus randomized
// strobes against a digit-queue reference model.
module tb_bcd_entry;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  bcd_entry_if bus ();

  bcd_entry #(.TIMEOUT_CYC(32'(TO))) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int digs[$];
  bit in_chk;
  int chk_v;
  int m_val;
  int idle_n;
  bit e_vv, e_err, e_tout;
  int mx;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    digs.delete();
    in_chk = 0;
    chk_v  = 0;
    m_val  = 0;
    idle_n = 0;
    e_vv   = 0;
    e_err  = 0;
    e_tout = 0;
  endfunction

  function automatic int entry_value();
    if (digs.size() == 1) return digs[0];
    return digs[0] * 10 + digs[1];
  endfunction

  function automatic void model_step(input bit c, input bit e, input bit v,
                                     input int d, input int m);
    e_vv = 0; e_err = 0; e_tout = 0;
    if (in_chk) begin
      in_chk = 0;
      digs.delete();
      if (!c) begin
        if (chk_v <= 31 && chk_v <= m) begin
          m_val = chk_v;
          e_vv  = 1;
        end else begin
          e_err = 1;
        end
      end
    end else if (c) begin
      digs.delete();
    end else if (e) begin
      if (digs.size() > 0) begin
        chk_v  = entry_value();
        in_chk = 1;
      end
    end else if (v && d <= 9 && digs.size() < 2) begin
      digs.push_back(d);
      idle_n = 0;
    end else if (digs.size() > 0) begin
`ifdef ENTRY_TIMEOUT_EN
      idle_n++;
      if (idle_n == TO) begin
        digs.delete();
        e_tout = 1;
      end
`endif
    end
  endfunction

  task automatic compare_all();
    int en, e1, e0;
    en = in_chk ? 0 : digs.size();
    e1 = (en == 2) ? digs[0] : 0;
    e0 = (en == 0) ? 0 : digs[en-1];
    check("val",     int'(bus.val),       m_val);
    check("val_vld", int'(bus.val_vld),   int'(e_vv));
    check("err",     int'(bus.err),       int'(e_err));
    check("tout",    int'(bus.tout),      int'(e_tout));
    check("ndig",    int'(bus.ndig),      en);
    check("disp1",   int'(bus.disp_bcd1), e1);
    check("disp0",   int'(bus.disp_bcd0), e0);
    check("pulse_excl", int'((int'(bus.val_vld) + int'(bus.err) + int'(bus.tout)) > 1), 0);
  endtask

  task automatic step(input bit c, input bit e, input bit v, input int d);
    bus.clr     = c;
    bus.ent     = e;
    bus.dig_vld = v;
    bus.dig     = 4'(d);
    bus.maxv    = 5'(mx);
    @(posedge clk);
    model_step(c, e, v, d, mx);
    #1;
    compare_all();
  endtask

  task automatic key(input int d);  step(0, 0, 1, d); endtask
  task automatic enter();           step(0, 1, 0, 0); endtask
  task automatic idle();            step(0, 0, 0, 0); endtask

  initial begin
    rst_n       = 1'b0;
    bus.dig     = '0;
    bus.dig_vld = 1'b0;
    bus.ent     = 1'b0;
    bus.clr     = 1'b0;
    bus.maxv    = '0;
    mx          = 31;
    model_reset();
    #3;
    compare_all();
    check("rst_val", int'(bus.val), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    enter();                               // ENT in IDLE ignored
    check("ent_idle_ndig", int'(bus.ndig), 0);

    // accept 27, then reject it on MAXV=20
    key(2); key(7);
    check("d38_ndig", int'(bus.ndig), 2);
    check("d38_disp1", int'(bus.disp_bcd1), 2);
    check("d38_disp0", int'(bus.disp_bcd0), 7);
    enter();
    check("d38_no_early", int'(bus.val_vld), 0);
    idle();
    check("d38_vv", int'(bus.val_vld), 1);
    check("d38_val", int'(bus.val), 27);
    mx = 20;
    key(2); key(7); enter(); idle();
    check("d38_err", int'(bus.err), 1);
    check("d38_hold", int'(bus.val), 27);

    // 45 exceeds the 5-bit range
    mx = 31;
    key(4); key(5); enter(); idle();
    check("d39_err", int'(bus.err), 1);
    check("d39_val", int'(bus.val), 27);
    check("d39_ndig", int'(bus.ndig), 0);

    // single digit, invalid key, third digit
    key(9); enter(); idle();
    check("d40_val", int'(bus.val), 9);
    key(1); key(12);
    check("d40_inv", int'(bus.ndig), 1);
    key(3); key(8);
    check("d40_third1", int'(bus.disp_bcd1), 1);
    check("d40_third0", int'(bus.disp_bcd0), 3);
    step(1, 0, 0, 0);

    // CLR beats ENT; CLR during CHECK aborts
    key(1); key(5); step(1, 1, 1, 4);
    check("d41_ndig", int'(bus.ndig), 0);
    idle();
    check("d41_no_vv", int'(bus.val_vld), 0);
    key(1); key(5); enter(); step(1, 0, 0, 0);
    check("d41_abort_vv", int'(bus.val_vld), 0);
    check("d41_abort_err", int'(bus.err), 0);
    check("d41_val", int'(bus.val), 9);

    // async reset mid-entry
    key(1); key(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("d42_val", int'(bus.val), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    key(6);
    check("d42_after", int'(bus.disp_bcd0), 6);
    step(1, 0, 0, 0);

    // inactivity
    key(3);
    for (int i = 0; i < 7; i++) idle();
`ifdef ENTRY_TIMEOUT_EN
    check("d43_pre", int'(bus.ndig), 1);
    idle();
    check("d43_tout", int'(bus.tout), 1);
    check("d43_ndig", int'(bus.ndig), 0);
`else
    for (int i = 0; i < 93; i++) idle();
    check("d43_hold", int'(bus.ndig), 1);
    check("d43_tout", int'(bus.tout), 0);
    step(1, 0, 0, 0);
`endif

    // randomized strobes
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit c, e, v;
      r  = int'($urandom_range(0, 99));
      c  = (r < 4);
      e  = (r >= 4 && r < 18) || ($urandom_range(0, 19) == 0);
      v  = (r >= 18 && r < 55) || ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mx = int'($urandom_range(0, 31));
      step(c, e, v, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
